bmem_initiator: RTL and testbench
=================================

# bmem_initiator

Processor-side initiator for the BMemory byte-addressed memory. The block accepts one data-port client (memory stage: loads/stores) and one fetch client (fetch stage: 10-byte instruction window) and serialises them onto BMemory's shared request pins. It drives `mem_read`/`mem_write`/`mem_addr`/`mem_data`/`pc`, captures `valM`/`ibytes` together with their status flags `m_ok`/`i_ok`, and returns one response per accepted request.

## Interface
- `ADDR_W`, 64, address / PC width
- `DATA_W`, 64, data word width
- `IB_W`, 80, instruction window width (10 bytes)

- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  synchronous active-low reset
- `d_valid`  in  1  data request valid
- `d_ready`  out  1  data request accepted this cycle
- `d_write`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data byte address
- `d_wdata`  in  DATA_W  store data
- `d_resp`  out  1  one-cycle data response pulse
- `d_rdata`  out  DATA_W  load data; 0 on error and for stores
- `d_err`  out  1  `!m_ok` captured for this transaction
- `f_valid`  in  1  fetch request valid
- `f_ready`  out  1  fetch accepted this cycle
- `f_pc`  in  ADDR_W  fetch address
- `f_resp`  out  1  one-cycle fetch response pulse
- `f_ibytes`  out  IB_W  instruction bytes; 0 on error
- `f_err`  out  1  `!i_ok` captured
- `mem_read`, `mem_write`  out  1  BMemory data strobes
- `mem_addr`, `mem_data`  out  ADDR_W / DATA_W  BMemory data address and write data
- `pc`  out  ADDR_W  BMemory fetch address
- `valM`  in  DATA_W  BMemory read data
- `ibytes`  in  IB_W  BMemory fetch bytes
- `m_ok`, `i_ok`  in  1  BMemory address-valid flags

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: the arbiter picks one client with valid high and raises only that client's ready (combinational). On an edge with valid&&ready, the request fields are latched, the port (D or F) is recorded, and the FSM moves to ISSUE. With no valid, the FSM stays in IDLE.
- ISSUE (one cycle):
  - D: `mem_addr` = latched addr. `mem_read` = !write, `mem_write` = write, `mem_data` = wdata.
  - F: `pc` = latched pc. Both strobes stay low.
  - Next state: CAPTURE.
- CAPTURE (one cycle): strobes are low and BMemory outputs are stable. At the edge, register:
  - D load: `d_rdata` = `valM` when `m_ok`, otherwise 0. `d_err` = `!m_ok`.
  - D store: `d_rdata` = 0. `d_err` = `!m_ok`.
  - F: `f_ibytes` = `ibytes` when `i_ok`, otherwise 0. `f_err` = `!i_ok`.
  - Next state: RESP.
- RESP: `d_resp` or `f_resp` is high for exactly one cycle, then the FSM returns to IDLE. Response data/err hold until the next response on the same port.
- Arbitration: round-robin on a `last_grant` bit. After reset, data has priority. When only one client is valid, it wins regardless of `last_grant`.
- `mem_addr`, `mem_data`, `pc` hold their last driven value outside ISSUE.

## Timing
- Reset (synchronous, `reset_n`=0 at an edge): FSM→IDLE, `last_grant`→fetch (so data wins first). All outputs are 0: strobes, `mem_addr`, `mem_data`, `pc`, resp pulses, rdata, ibytes, err.
- Reset in ISSUE/CAPTURE/RESP: the transaction is dropped with no response. Strobes are low from the first cycle after the reset edge. A store whose ISSUE cycle completed has already been written.
- Latency: accept edge at the end of cycle N. ISSUE in N+1, CAPTURE in N+2, resp pulse in N+3. Throughput is one transaction per 4 cycles; a new accept is possible in cycle N+4.
- ready is never high outside IDLE. At most one ready per cycle. Clients must hold their fields stable only while valid && !ready.
- A write strobe is exactly one cycle per accepted store; there are no retries.

## Structure
- Package `bmem_pkg`: state enum `bmem_state_t` {IDLE, ISSUE, CAPTURE, RESP}, port enum {PORT_D, PORT_F}, width constants ADDR_W/DATA_W/IB_W.
- Sub-module `bmem_arb2`: 2-way round-robin arbiter (req[1:0], enable, grant[1:0], last_grant register), reused later by the pipelined variant.

## Test plan
- Store then load: store `d_addr`=0, `d_wdata`=0x0123456789abcdef → `mem_write` high for exactly 1 cycle, `d_resp` at N+3 with `d_err`=0. Load addr 0 → `d_rdata`=0x0123456789abcdef, `d_err`=0.
- Fetch: after the store above, `f_pc`=0 → `f_ibytes[63:0]`=0x0123456789abcdef, `f_err`=0, `mem_read`/`mem_write` stay 0 throughout.
- Out-of-range: load at addr 0xFFFF_FFFF_FFFF_FFF0 with the model returning `m_ok`=0 → `d_err`=1, `d_rdata`=0.
- Contention: `d_valid` and `f_valid` held high from reset for 4 transactions → grant order D, F, D, F, with one ready per IDLE visit and no overlapping strobes.
- Reset mid-op: deassert `reset_n` in the ISSUE cycle of a load to addr 2 → no `d_resp`, strobes 0 the next cycle, all outputs 0, and the next request completes normally.
- Back-to-back stores to addr 2 and 3 with valid kept high → the second is accepted exactly 4 cycles after the first, and each gets exactly one `mem_write` pulse.

Source files
------------

// File: rtl/bmem_pkg.sv
// Shared types and widths for the BMemory initiator and its arbiter.
package bmem_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int IB_W   = 80;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } bmem_state_t;

  // The value of each port doubles as its request/grant bit index.
  typedef enum logic {
    PORT_D = 1'b0,
    PORT_F = 1'b1
  } bmem_port_t;

endpackage

// File: rtl/bmem_arb2.sv
// Two-way round-robin arbiter; a lone requester always wins, ties alternate.
module bmem_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);

  logic last_grant_q, last_grant_d;

  // NOTE: every output of this block is assigned before any branch, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant        = 2'b00;
    last_grant_d = last_grant_q;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
    if (grant[1]) begin
      last_grant_d = 1'b1;
    end else if (grant[0]) begin
      last_grant_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;  // pretend fetch went last so data wins first
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/bmem_initiator.sv
// BMemory initiator: serialises a data client and a fetch client onto the
// shared BMemory pins, one transaction per four cycles.
module bmem_initiator
  import bmem_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  input  logic              f_valid,
  output logic              f_ready,
  input  logic [ADDR_W-1:0] f_pc,
  output logic              f_resp,
  output logic [IB_W-1:0]   f_ibytes,
  output logic              f_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] valM,
  input  logic [IB_W-1:0]   ibytes,
  input  logic              m_ok,
  input  logic              i_ok
);

  bmem_state_t       state_q, state_d;
  bmem_port_t        port_q, port_d;
  logic              write_q, write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_err_q, d_err_d;
  logic [IB_W-1:0]   f_ibytes_q, f_ibytes_d;
  logic              f_err_q, f_err_d;
  logic [1:0]        grant;

  bmem_arb2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     ({f_valid, d_valid}),
    .enable  (state_q == IDLE),
    .grant   (grant)
  );

  // BMemory pins are loaded on the accept edge, so they are live for exactly
  // the ISSUE cycle and then simply hold.
  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    write_d     = write_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    pc_d        = pc_q;
    d_rdata_d   = d_rdata_q;
    d_err_d     = d_err_q;
    f_ibytes_d  = f_ibytes_q;
    f_err_d     = f_err_q;
    case (state_q)
      IDLE: begin
        if (grant[PORT_D]) begin
          state_d     = ISSUE;
          port_d      = PORT_D;
          write_d     = d_write;
          mem_read_d  = !d_write;
          mem_write_d = d_write;
          mem_addr_d  = d_addr;
          mem_data_d  = d_wdata;
        end else if (grant[PORT_F]) begin
          state_d = ISSUE;
          port_d  = PORT_F;
          pc_d    = f_pc;
        end
      end
      ISSUE:   state_d = CAPTURE;
      CAPTURE: begin
        state_d = RESP;
        if (port_q == PORT_D) begin
          d_err_d   = !m_ok;
          d_rdata_d = (m_ok && !write_q) ? valM : '0;
        end else begin
          f_err_d    = !i_ok;
          f_ibytes_d = i_ok ? ibytes : '0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      port_q      <= PORT_D;
      write_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      pc_q        <= '0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
      f_ibytes_q  <= '0;
      f_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      write_q     <= write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      pc_q        <= pc_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
      f_ibytes_q  <= f_ibytes_d;
      f_err_q     <= f_err_d;
    end
  end

  assign d_ready   = grant[PORT_D];
  assign f_ready   = grant[PORT_F];
  assign d_resp    = (state_q == RESP) && (port_q == PORT_D);
  assign f_resp    = (state_q == RESP) && (port_q == PORT_F);
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign f_ibytes  = f_ibytes_q;
  assign f_err     = f_err_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_bmem_initiator.sv
// Bench for bmem_initiator: a 256-byte BMemory model, randomized client
// traffic, and a scoreboard fed at accept time from a byte-array reference.
module tb_bmem_initiator;
  import bmem_pkg::*;

  localparam int MEM_SIZE = 256;

  typedef struct { logic write; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata; } d_req_t;
  typedef struct { logic [DATA_W-1:0] rdata; logic err; int cyc; } d_exp_t;
  typedef struct { logic [IB_W-1:0] ib; logic err; int cyc; } f_exp_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_t;
  typedef struct { bit is_f; int cyc; } acc_t;

  logic              clock, reset_n;
  logic              d_valid, d_ready, d_write, d_resp, d_err;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic              f_valid, f_ready, f_resp, f_err;
  logic [ADDR_W-1:0] f_pc;
  logic [IB_W-1:0]   f_ibytes;
  logic              mem_read, mem_write, m_ok, i_ok;
  logic [ADDR_W-1:0] mem_addr, pc;
  logic [DATA_W-1:0] mem_data, valM;
  logic [IB_W-1:0]   ibytes;

  bmem_initiator dut (
    .clock(clock), .reset_n(reset_n),
    .d_valid(d_valid), .d_ready(d_ready), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata), .d_err(d_err),
    .f_valid(f_valid), .f_ready(f_ready), .f_pc(f_pc), .f_resp(f_resp),
    .f_ibytes(f_ibytes), .f_err(f_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data(mem_data), .pc(pc), .valM(valM), .ibytes(ibytes),
    .m_ok(m_ok), .i_ok(i_ok)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Environment: BMemory answers combinationally and writes on the edge.
  logic [7:0] bmem [MEM_SIZE] = '{default: 8'h00};
  logic [7:0] gold [MEM_SIZE] = '{default: 8'h00};

  function automatic logic fits(input logic [ADDR_W-1:0] a, input int n);
    return a <= ADDR_W'(MEM_SIZE - n);
  endfunction

  always_comb begin
    m_ok   = fits(mem_addr, 8);
    i_ok   = fits(pc, 10);
    valM   = '0;
    ibytes = '0;
    if (m_ok) for (int i = 0; i < 8; i++) valM[8*i +: 8] = bmem[int'(mem_addr[7:0]) + i];
    if (i_ok) for (int i = 0; i < 10; i++) ibytes[8*i +: 8] = bmem[int'(pc[7:0]) + i];
  end

  always @(posedge clock)
    if (mem_write && fits(mem_addr, 8))
      for (int i = 0; i < 8; i++) bmem[int'(mem_addr[7:0]) + i] <= mem_data[8*i +: 8];

  function automatic logic [IB_W-1:0] gold_bytes(input logic [ADDR_W-1:0] a, input int n);
    logic [IB_W-1:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = gold[int'(a[7:0]) + i];
    return v;
  endfunction

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [IB_W-1:0] act, input logic [IB_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got event, expected none (cycle %0d)", name, cyc);
  endtask

  d_req_t            d_req_q [$];
  logic [ADDR_W-1:0] f_req_q [$];
  d_exp_t            d_q [$];
  f_exp_t            f_q [$];
  wr_t               wr_q [$];
  logic [ADDR_W-1:0] rd_q [$];
  acc_t              acc_log [$];
  bit                last_gnt_f = 1'b1;
  bit                mon_en = 1'b0;

  // Scoreboard monitor: pops one expectation per strobe / response pulse.
  always @(negedge clock) begin : mon
    wr_t    w;
    d_exp_t de;
    f_exp_t fe;
    if (mon_en) begin
      if (mem_write) begin
        check("strobe_excl", IB_W'(mem_read), '0);
        if (wr_q.size() == 0) fail_now("unexpected_mem_write");
        else begin
          w = wr_q.pop_front();
          check("wr_addr", IB_W'(mem_addr), IB_W'(w.addr));
          check("wr_data", IB_W'(mem_data), IB_W'(w.data));
        end
      end
      if (mem_read) begin
        if (rd_q.size() == 0) fail_now("unexpected_mem_read");
        else check("rd_addr", IB_W'(mem_addr), IB_W'(rd_q.pop_front()));
      end
      if (d_resp) begin
        if (d_q.size() == 0) fail_now("unexpected_d_resp");
        else begin
          de = d_q.pop_front();
          check("d_rdata", IB_W'(d_rdata), IB_W'(de.rdata));
          check("d_err", IB_W'(d_err), IB_W'(de.err));
          check("d_latency", IB_W'(cyc), IB_W'(de.cyc));
        end
      end
      if (f_resp) begin
        if (f_q.size() == 0) fail_now("unexpected_f_resp");
        else begin
          fe = f_q.pop_front();
          check("f_ibytes", f_ibytes, fe.ib);
          check("f_err", IB_W'(f_err), IB_W'(fe.err));
          check("f_latency", IB_W'(cyc), IB_W'(fe.cyc));
        end
      end
    end
  end

  task automatic accept_d();
    d_req_t          r = d_req_q[0];
    d_exp_t          e;
    logic [IB_W-1:0] b;
    acc_log.push_back('{1'b0, cyc});
    last_gnt_f = 1'b0;
    e.err   = !fits(r.addr, 8);
    e.cyc   = cyc + 3;
    e.rdata = '0;
    if (r.write) begin
      wr_q.push_back('{r.addr, r.wdata});
      if (!e.err) for (int i = 0; i < 8; i++) gold[int'(r.addr[7:0]) + i] = r.wdata[8*i +: 8];
    end else begin
      rd_q.push_back(r.addr);
      if (!e.err) begin
        b = gold_bytes(r.addr, 8);
        e.rdata = b[DATA_W-1:0];
      end
    end
    d_q.push_back(e);
  endtask

  task automatic accept_f();
    f_exp_t e;
    acc_log.push_back('{1'b1, cyc});
    last_gnt_f = 1'b1;
    e.err = !fits(f_req_q[0], 10);
    e.cyc = cyc + 3;
    e.ib  = e.err ? '0 : gold_bytes(f_req_q[0], 10);
    f_q.push_back(e);
  endtask

  task automatic present();
    if (d_req_q.size() > 0) begin
      d_valid = 1'b1;
      d_write = d_req_q[0].write;
      d_addr  = d_req_q[0].addr;
      d_wdata = d_req_q[0].wdata;
    end else begin
      d_valid = 1'b0;
      d_addr  = {$urandom, $urandom};
      d_wdata = {$urandom, $urandom};
    end
    if (f_req_q.size() > 0) begin
      f_valid = 1'b1;
      f_pc    = f_req_q[0];
    end else begin
      f_valid = 1'b0;
      f_pc    = {$urandom, $urandom};
    end
  endtask

  // Keeps each client's valid high until its queued requests are all accepted.
  task automatic drive();
    int budget = 0;
    bit d_acc, f_acc;
    present();
    while (d_valid || f_valid) begin
      @(negedge clock);
      d_acc = d_valid && d_ready;
      f_acc = f_valid && f_ready;
      if (d_ready || f_ready) check("one_ready", IB_W'(d_ready && f_ready), '0);
      if (d_valid && f_valid && (d_ready || f_ready))
        check("rr_grant", IB_W'(f_ready), IB_W'(!last_gnt_f));
      if (d_acc) accept_d();
      if (f_acc) accept_f();
      @(posedge clock);
      #1;
      if (d_acc) void'(d_req_q.pop_front());
      if (f_acc) void'(f_req_q.pop_front());
      present();
      if (++budget > 100) begin
        fail_now("drive_timeout");
        d_req_q.delete();
        f_req_q.delete();
        present();
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_pulses"}, IB_W'({d_resp, f_resp, mem_read, mem_write, d_err, f_err}), '0);
    check({name, "_d_rdata"}, IB_W'(d_rdata), '0);
    check({name, "_f_ibytes"}, f_ibytes, '0);
    check({name, "_mem_addr"}, IB_W'(mem_addr), '0);
    check({name, "_mem_data"}, IB_W'(mem_data), '0);
    check({name, "_pc"}, IB_W'(pc), '0);
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr(input int n);
    case ($urandom_range(0, 9))
      0:       return 64'hFFFF_FFFF_FFFF_FFF0;
      1:       return ADDR_W'(MEM_SIZE - n);
      2:       return ADDR_W'(MEM_SIZE - n + 1);
      default: return ADDR_W'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    d_valid = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    f_valid = 1'b0; f_pc = '0;
    idle(3);
    @(negedge clock);
    check_all_zero("reset");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Store, load back, fetch the same bytes, then an out-of-range load.
    d_req_q.push_back('{1'b1, 64'h0, 64'h0123456789abcdef});
    drive();
    d_req_q.push_back('{1'b0, 64'h0, 64'h0});
    drive();
    f_req_q.push_back(64'h0);
    drive();
    idle(5);
    check("fetch_low64", IB_W'(f_ibytes[63:0]), IB_W'(64'h0123456789abcdef));
    d_req_q.push_back('{1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0});
    drive();
    idle(5);
    check("oor_err", IB_W'(d_err), IB_W'(1'b1));
    check("oor_rdata", IB_W'(d_rdata), '0);

    // Both clients valid straight out of reset.
    reset_n    = 1'b0;
    last_gnt_f = 1'b1;
    idle(2);
    reset_n = 1'b1;
    acc_log.delete();
    repeat (2) begin
      d_req_q.push_back('{1'($urandom_range(0, 1)), rand_addr(8), {$urandom, $urandom}});
      f_req_q.push_back(rand_addr(10));
    end
    drive();
    idle(5);
    check("contention_count", IB_W'(acc_log.size()), IB_W'(4));
    for (int i = 0; i < acc_log.size(); i++) begin
      check("contention_order", IB_W'(acc_log[i].is_f), IB_W'(i % 2));
      if (i > 0) check("contention_gap", IB_W'(acc_log[i].cyc - acc_log[i-1].cyc), IB_W'(4));
    end

    // Reset during the ISSUE cycle of a load drops it.
    d_req_q.push_back('{1'b0, 64'd2, 64'h0});
    drive();
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    d_q.delete();
    last_gnt_f = 1'b1;
    @(negedge clock);
    check_all_zero("midop");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(4);
    d_req_q.push_back('{1'b0, 64'd2, 64'h0});
    drive();
    idle(5);

    // Back-to-back stores with valid held high.
    acc_log.delete();
    d_req_q.push_back('{1'b1, 64'd2, {$urandom, $urandom}});
    d_req_q.push_back('{1'b1, 64'd3, {$urandom, $urandom}});
    drive();
    idle(5);
    check("b2b_count", IB_W'(acc_log.size()), IB_W'(2));
    if (acc_log.size() == 2)
      check("b2b_gap", IB_W'(acc_log[1].cyc - acc_log[0].cyc), IB_W'(4));

    // Randomized mixed traffic.
    for (int r = 0; r < 40; r++) begin
      repeat ($urandom_range(0, 2))
        d_req_q.push_back('{1'($urandom_range(0, 1)), rand_addr(8), {$urandom, $urandom}});
      repeat ($urandom_range(0, 2)) f_req_q.push_back(rand_addr(10));
      drive();
      idle($urandom_range(0, 3));
    end

    idle(8);
    check("d_q_drained", IB_W'(d_q.size()), '0);
    check("f_q_drained", IB_W'(f_q.size()), '0);
    check("wr_q_drained", IB_W'(wr_q.size()), '0);
    check("rd_q_drained", IB_W'(rd_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
